// File: rtl/gpio_pkg.sv
// Register address map shared by the GPIO output and input ports.
package gpio_pkg;

    localparam logic [3:0] GPIO_OUT_DATA   = 4'h0;

    localparam logic [3:0] GPIO_IN_DATA    = 4'h0;
    localparam logic [3:0] GPIO_IN_RISE_EN = 4'h1;
    localparam logic [3:0] GPIO_IN_FALL_EN = 4'h2;
    localparam logic [3:0] GPIO_IN_FLAGS   = 4'h3;
    localparam logic [3:0] GPIO_IN_IRQ_EN  = 4'h4;

endpackage

// File: rtl/gpio_debounce.sv
// One pin: synchronizer chain, stable-cycle counter and filtered level F.
// 'changed' is high on the edge where F is about to take a new value.
module gpio_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    input  logic prime,
    output logic level,
    output logic changed
);

    localparam int D  = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES : 1;
    localparam int CW = (D > 1) ? $clog2(D) : 1;

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          count;
    logic                   s;
    logic                   settle;

    assign s       = sync[SYNC_STAGES-1];
    assign settle  = (s != level) && (count == CW'(D - 1));
    assign changed = settle & ~prime;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync  <= '0;
            count <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            if (prime) begin
                // Load the value S takes on this edge so F already equals S
                // when priming ends; a pin high through reset never looks like a rise.
                level <= sync[SYNC_STAGES-2];
                count <= '0;
            end else if (s == level) begin
                count <= '0;
            end else if (settle) begin
                level <= s;
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_input.sv
// Input GPIO port: filtered pin levels, sticky edge flags with enables,
// and one level interrupt. Register reads are combinational.
module gpio_input
    import gpio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_phyPINS,
    input  logic [3:0]       i_addr,
    input  logic             i_wrEnable,
    input  logic [WIDTH-1:0] i_wrData,
    output logic [WIDTH-1:0] o_rdData,
    output logic             o_irq
);

    localparam int PW = $clog2(SYNC_STAGES + 1);

    logic [PW-1:0]    prime_cnt;
    logic             prime;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] changed;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] clear;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] flags;
    logic [WIDTH-1:0] irq_en;

    assign prime = (prime_cnt != PW'(SYNC_STAGES));

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock  (i_clock),
            .reset  (i_reset),
            .pin    (i_phyPINS[i]),
            .prime  (prime),
            .level  (level[i]),
            .changed(changed[i])
        );
    end

    assign rise  = ~level & changed;
    assign fall  =  level & changed;
    assign clear = (i_wrEnable && i_addr == GPIO_IN_FLAGS) ? i_wrData : '0;
    assign o_irq = |(flags & irq_en);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            prime_cnt <= '0;
            rise_en   <= '0;
            fall_en   <= '0;
            flags     <= '0;
            irq_en    <= '0;
        end else begin
            if (prime) prime_cnt <= prime_cnt + PW'(1);
            if (i_wrEnable) begin
                case (i_addr)
                    GPIO_IN_RISE_EN: rise_en <= i_wrData;
                    GPIO_IN_FALL_EN: fall_en <= i_wrData;
                    GPIO_IN_IRQ_EN:  irq_en  <= i_wrData;
                    default: ;
                endcase
            end
            // A new event on the same edge as a W1C keeps the flag set.
            flags <= (flags & ~clear) | (rise & rise_en) | (fall & fall_en);
        end
    end

    always_comb begin
        o_rdData = '0;
        case (i_addr)
            GPIO_IN_DATA:    o_rdData = level;
            GPIO_IN_RISE_EN: o_rdData = rise_en;
            GPIO_IN_FALL_EN: o_rdData = fall_en;
            GPIO_IN_FLAGS:   o_rdData = flags;
            GPIO_IN_IRQ_EN:  o_rdData = irq_en;
            default:         o_rdData = '0;
        endcase
    end

endmodule

// File: tb/tb_gpio_input.sv
// Directed bench for gpio_input: one unfiltered instance (D=0) and one with a
// 4-cycle debounce share every input; expected values go through exp_q.
module tb_gpio_input;
    import gpio_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pins;
    logic [3:0] addr;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] rd0, rd4;
    logic       irq0, irq4;

    logic [7:0] exp_q[$];
    int         n_assert = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    gpio_input #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut0 (
        .i_clock(clk), .i_reset(rst), .i_phyPINS(pins), .i_addr(addr),
        .i_wrEnable(wr), .i_wrData(wdata), .o_rdData(rd0), .o_irq(irq0)
    );

    gpio_input #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut4 (
        .i_clock(clk), .i_reset(rst), .i_phyPINS(pins), .i_addr(addr),
        .i_wrEnable(wr), .i_wrData(wdata), .o_rdData(rd4), .o_irq(irq4)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        tick();
        wr    = 1'b0;
        wdata = 8'h00;
    endtask

    task automatic compare(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        e = exp_q.pop_front();
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic check_rd(input string tag, input bit sel4,
                            input logic [3:0] a, input logic [7:0] e);
        exp_q.push_back(e);
        addr = a;
        #1;
        compare(tag, sel4 ? rd4 : rd0);
    endtask

    task automatic check_irq(input string tag, input bit sel4, input logic e);
        exp_q.push_back({7'b0, e});
        #1;
        compare(tag, {7'b0, sel4 ? irq4 : irq0});
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 16; a++) begin
            check_rd(tag, 1'b0, 4'(a), 8'h00);
            check_rd(tag, 1'b1, 4'(a), 8'h00);
        end
        check_irq(tag, 1'b0, 1'b0);
        check_irq(tag, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; pins = 8'hFF; addr = 4'h0; wr = 1'b0; wdata = 8'h00;
        tick(2);
        check_all_zero("reset");

        // Test 1: pins high through reset, priming must not raise flags
        rst = 1'b0;
        write_reg(GPIO_IN_RISE_EN, 8'hFF);
        tick();
        check_rd("prime_data", 1'b0, GPIO_IN_DATA, 8'hFF);
        check_rd("prime_data4", 1'b1, GPIO_IN_DATA, 8'hFF);
        tick(8);
        check_rd("prime_flags", 1'b0, GPIO_IN_FLAGS, 8'h00);
        check_rd("prime_flags4", 1'b1, GPIO_IN_FLAGS, 8'h00);
        check_irq("prime_irq", 1'b0, 1'b0);

        // Test 2: pin0 rise, D=0 latency of three edges
        pins = 8'hFE;
        tick(8);
        check_rd("fall_noflag", 1'b0, GPIO_IN_FLAGS, 8'h00);
        write_reg(GPIO_IN_RISE_EN, 8'h01);
        write_reg(GPIO_IN_IRQ_EN, 8'h01);
        pins = 8'hFF;
        tick(2);
        check_rd("rise_early_data", 1'b0, GPIO_IN_DATA, 8'hFE);
        check_rd("rise_early_flags", 1'b0, GPIO_IN_FLAGS, 8'h00);
        check_irq("rise_early_irq", 1'b0, 1'b0);
        tick();
        check_rd("rise_data", 1'b0, GPIO_IN_DATA, 8'hFF);
        check_rd("rise_flags", 1'b0, GPIO_IN_FLAGS, 8'h01);
        check_irq("rise_irq", 1'b0, 1'b1);

        // Test 3: debounce on the D=4 instance
        pins = 8'hF7;
        tick(10);
        write_reg(GPIO_IN_RISE_EN, 8'h08);
        write_reg(GPIO_IN_FLAGS, 8'hFF);
        pins = 8'hFF;
        tick(3);
        pins = 8'hF7;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_rd("glitch_data4", 1'b1, GPIO_IN_DATA, 8'hF7);
            check_rd("glitch_flags4", 1'b1, GPIO_IN_FLAGS, 8'h00);
        end
        pins = 8'hFF;
        tick(5);
        check_rd("deb_early_data4", 1'b1, GPIO_IN_DATA, 8'hF7);
        tick();
        check_rd("deb_data4", 1'b1, GPIO_IN_DATA, 8'hFF);
        check_rd("deb_flags4", 1'b1, GPIO_IN_FLAGS, 8'h08);

        // Test 4: W1C, and W1C colliding with a new rise
        write_reg(GPIO_IN_RISE_EN, 8'h05);
        write_reg(GPIO_IN_FLAGS, 8'hFF);
        pins = 8'hFA;
        tick(10);
        pins = 8'hFF;
        tick(10);
        check_rd("flags05", 1'b0, GPIO_IN_FLAGS, 8'h05);
        check_rd("flags05_4", 1'b1, GPIO_IN_FLAGS, 8'h05);
        write_reg(GPIO_IN_FLAGS, 8'h04);
        check_rd("w1c", 1'b0, GPIO_IN_FLAGS, 8'h01);
        check_rd("w1c_4", 1'b1, GPIO_IN_FLAGS, 8'h01);
        pins = 8'hFB;
        tick(10);
        pins = 8'hFF;
        tick(2);
        check_rd("collide_pre", 1'b0, GPIO_IN_FLAGS, 8'h01);
        write_reg(GPIO_IN_FLAGS, 8'h04);
        check_rd("collide_set_wins", 1'b0, GPIO_IN_FLAGS, 8'h05);

        // Test 5: fall enable and IRQ masking
        tick(10);
        write_reg(GPIO_IN_FALL_EN, 8'h80);
        write_reg(GPIO_IN_IRQ_EN, 8'h00);
        write_reg(GPIO_IN_FLAGS, 8'hFF);
        pins = 8'h7F;
        tick(3);
        check_rd("fall_flags", 1'b0, GPIO_IN_FLAGS, 8'h80);
        check_irq("fall_irq_masked", 1'b0, 1'b0);
        write_reg(GPIO_IN_IRQ_EN, 8'h80);
        check_irq("fall_irq", 1'b0, 1'b1);
        write_reg(GPIO_IN_RISE_EN, 8'hFF);
        check_rd("no_retro_flags", 1'b0, GPIO_IN_FLAGS, 8'h80);
        write_reg(GPIO_IN_IRQ_EN, 8'h00);
        check_irq("irq_remask", 1'b0, 1'b0);
        check_rd("remask_flags", 1'b0, GPIO_IN_FLAGS, 8'h80);

        // Test 6: unmapped addresses, DATA write ignored, reset mid-debounce
        check_rd("rd_0x7", 1'b0, 4'h7, 8'h00);
        check_rd("rd_0xF", 1'b0, 4'hF, 8'h00);
        write_reg(4'h7, 8'hFF);
        write_reg(GPIO_IN_DATA, 8'h00);
        check_rd("data_wr_ignored", 1'b0, GPIO_IN_DATA, 8'h7F);
        pins = 8'hFF;
        tick(3);
        check_rd("data_tracks", 1'b0, GPIO_IN_DATA, 8'hFF);
        check_rd("unmapped_wr", 1'b0, 4'h7, 8'h00);
        write_reg(GPIO_IN_IRQ_EN, 8'hFF);
        tick(6);
        pins = 8'h7F;
        tick(4);
        check_rd("mid_deb_data4", 1'b1, GPIO_IN_DATA, 8'hFF);
        rst = 1'b1;
        tick();
        check_all_zero("reset_mid");
        rst = 1'b0;
        tick(2);
        check_rd("reprime_data", 1'b0, GPIO_IN_DATA, 8'h7F);
        check_rd("reprime_data4", 1'b1, GPIO_IN_DATA, 8'h7F);
        check_rd("reprime_flags", 1'b0, GPIO_IN_FLAGS, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
